// File: rtl/edge_rate_meter.sv
// edge_rate_meter: counts rising edges of an asynchronous pin over a gate window
// of GATE_CYCLES enabled clocks, then publishes a saturated count plus an
// overflow flag with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   ena             counting and the window timer advance only while high
//   sig_in          asynchronous measured signal
//   clear           synchronous restart of the current window (outputs kept)
//   count_out       edge count of the last completed window (saturating)
//   overflow        last completed window saturated
//   valid           one-cycle pulse when count_out/overflow update
module edge_rate_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow,
    output logic             valid
);

    localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX   = '1;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             edge_det;
    logic [CNT_W-1:0] acc;
    logic             ovf_acc;
    logic [GW-1:0]    gate_cnt;
    logic             acc_at_max;
    logic             win_end;
    logic [CNT_W-1:0] cnt_final;
    logic             ovf_final;

    // Two flops resolve metastability; s3 is the edge-history flop. The
    // chain runs regardless of ena/clear so a rising edge is never smeared
    // across an enable transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det   = s2 & ~s3;
    assign acc_at_max = (acc == ACC_MAX);
    assign win_end    = ena && (gate_cnt == GATE_LAST);

    // An edge landing on the final window cycle is folded into the
    // published result rather than carried into the next window.
    assign cnt_final = (edge_det && !acc_at_max) ? acc + 1'b1 : acc;
    assign ovf_final = ovf_acc | (edge_det & acc_at_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            gate_cnt  <= '0;
            count_out <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                acc      <= '0;
                ovf_acc  <= 1'b0;
                gate_cnt <= '0;
            end else if (win_end) begin
                count_out <= cnt_final;
                overflow  <= ovf_final;
                valid     <= 1'b1;
                acc       <= '0;
                ovf_acc   <= 1'b0;
                gate_cnt  <= '0;
            end else if (ena) begin
                gate_cnt <= gate_cnt + 1'b1;
                if (edge_det) begin
                    if (acc_at_max) begin
                        ovf_acc <= 1'b1;
                    end else begin
                        acc <= acc + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_rate_meter.sv
// tb_edge_rate_meter: directed vectors for edge_rate_meter, one instance with
// a 16-cycle window and one with a 64-cycle window (both 4-bit counts).
// Expected results are queued when stimulus is issued; monitors pop on valid.
module tb_edge_rate_meter;

    typedef struct {
        int cnt;
        bit ovf;
        int pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       ena64 = 1'b0;
    logic       sig = 1'b0;
    logic       sig64 = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] count_a;
    logic       ovf_a;
    logic       valid_a;
    logic [3:0] count_b;
    logic       ovf_b;
    logic       valid_b;

    int   pc = 0;
    int   base = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   last_cnt_a = 0;
    bit   last_ovf_a = 1'b0;
    int   last_cnt_b = 0;
    bit   last_ovf_b = 1'b0;

    edge_rate_meter #(.GATE_CYCLES(16), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig), .clear(clear),
        .count_out(count_a), .overflow(ovf_a), .valid(valid_a)
    );

    edge_rate_meter #(.GATE_CYCLES(64), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena64), .sig_in(sig64), .clear(clear),
        .count_out(count_b), .overflow(ovf_b), .valid(valid_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc = pc + 1;

    function automatic void chk_out(input string nm, input exp_t e,
                                    input logic [3:0] cnt, input logic ovf, input int at);
        n_vec++;
        if (cnt !== 4'(e.cnt) || ovf !== e.ovf || at != e.pc) begin
            n_bad++;
            $display("FAIL %s: got count=%0d ovf=%0b at pc=%0d, want count=%0d ovf=%0b at pc=%0d",
                     nm, cnt, ovf, at, e.cnt, e.ovf, e.pc);
        end
    endfunction

    function automatic exp_t mk(input int cnt, input bit ovf, input int at);
        exp_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        e.pc  = at;
        return e;
    endfunction

    // Monitor for the 16-cycle instance.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_n) begin
            last_cnt_a = 0;
            last_ovf_a = 1'b0;
        end else if (valid_a) begin
            if (qa.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid_a: got valid at pc=%0d count=%0d, want no valid", pc, count_a);
            end else begin
                e = qa.pop_front();
                chk_out("window_a", e, count_a, ovf_a, pc);
                last_cnt_a = e.cnt;
                last_ovf_a = e.ovf;
            end
        end else if (count_a !== 4'(last_cnt_a) || ovf_a !== last_ovf_a) begin
            n_bad++;
            $display("FAIL hold_a: got count=%0d ovf=%0b at pc=%0d, want count=%0d ovf=%0b",
                     count_a, ovf_a, pc, last_cnt_a, last_ovf_a);
        end
    end

    // Monitor for the 64-cycle instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_n) begin
            last_cnt_b = 0;
            last_ovf_b = 1'b0;
        end else if (valid_b) begin
            if (qb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid_b: got valid at pc=%0d count=%0d, want no valid", pc, count_b);
            end else begin
                e = qb.pop_front();
                chk_out("window_b", e, count_b, ovf_b, pc);
                last_cnt_b = e.cnt;
                last_ovf_b = e.ovf;
            end
        end else if (count_b !== 4'(last_cnt_b) || ovf_b !== last_ovf_b) begin
            n_bad++;
            $display("FAIL hold_b: got count=%0d ovf=%0b at pc=%0d, want count=%0d ovf=%0b",
                     count_b, ovf_b, pc, last_cnt_b, last_ovf_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just before posedge c of the current run (cycle 0 = first
    // posedge after reset release).
    task automatic to_cycle(input int c);
        while (pc < base + c) step();
    endtask

    // Three reset clocks with sig_in toggling; all outputs must read zero.
    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        ena64 = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig   = ~sig;
            sig64 = ~sig64;
            step();
            #3;
            n_vec++;
            if (count_a !== 4'd0 || ovf_a !== 1'b0 || valid_a !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_a: got count=%0d ovf=%0b valid=%0b, want 0 0 0", count_a, ovf_a, valid_a);
            end
            n_vec++;
            if (count_b !== 4'd0 || ovf_b !== 1'b0 || valid_b !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_b: got count=%0d ovf=%0b valid=%0b, want 0 0 0", count_b, ovf_b, valid_b);
            end
        end
        step();
        sig   = 1'b0;
        sig64 = 1'b0;
        rst_n = 1'b1;
        base  = pc;
    endtask

    // Per-cycle patterns: bit c applies to the cycle-c posedge.
    task automatic drive(input logic [159:0] ps, input logic [159:0] pe,
                         input logic [159:0] pcl, input int n, input bit sel);
        for (int c = 0; c < n; c++) begin
            to_cycle(c);
            if (sel) begin
                sig64 = ps[c];
                ena64 = pe[c];
                sig   = 1'b0;
                ena   = 1'b0;
            end else begin
                sig   = ps[c];
                ena   = pe[c];
                sig64 = 1'b0;
                ena64 = 1'b0;
            end
            clear = pcl[c];
        end
        to_cycle(n);
    endtask

    initial begin
        logic [159:0] ps;
        logic [159:0] pe;
        logic [159:0] pcl;

        // Five 1-high/1-low pulses, an empty window, then a window whose
        // second edge is counted exactly on the final cycle, then empty.
        do_reset();
        ps = '0; pe = '1; pcl = '0;
        for (int i = 0; i < 5; i++) ps[1 + 2 * i] = 1'b1;
        ps[33] = 1'b1; ps[34] = 1'b1;
        ps[45] = 1'b1; ps[46] = 1'b1;
        qa.push_back(mk(5, 1'b0, base + 16));
        qa.push_back(mk(0, 1'b0, base + 32));
        qa.push_back(mk(2, 1'b0, base + 48));
        qa.push_back(mk(0, 1'b0, base + 64));
        drive(ps, pe, pcl, 65, 1'b0);

        // Level held high across two windows: one edge only.
        do_reset();
        ps = '0; pe = '1; pcl = '0;
        for (int c = 1; c < 34; c++) ps[c] = 1'b1;
        qa.push_back(mk(1, 1'b0, base + 16));
        qa.push_back(mk(0, 1'b0, base + 32));
        drive(ps, pe, pcl, 34, 1'b0);

        // 64-cycle window: 31 edges saturate, then one carried edge + 2 more.
        do_reset();
        ps = '0; pe = '1; pcl = '0;
        for (int c = 1; c < 64; c += 2) ps[c] = 1'b1;
        ps[70] = 1'b1; ps[80] = 1'b1;
        qb.push_back(mk(15, 1'b1, base + 64));
        qb.push_back(mk(3, 1'b0, base + 128));
        drive(ps, pe, pcl, 129, 1'b1);

        // ena low for cycles 5..14: window stretches by 10, gap edges dropped.
        do_reset();
        ps = '0; pe = '1; pcl = '0;
        for (int c = 5; c < 15; c++) pe[c] = 1'b0;
        ps[1] = 1'b1; ps[7] = 1'b1; ps[10] = 1'b1; ps[16] = 1'b1; ps[19] = 1'b1;
        qa.push_back(mk(3, 1'b0, base + 26));
        drive(ps, pe, pcl, 27, 1'b0);

        // clear at cycle 24 restarts the window; the edge counted on the
        // clear cycle is dropped and count_out holds 3 until cycle 40.
        do_reset();
        ps = '0; pe = '1; pcl = '0;
        ps[1] = 1'b1; ps[3] = 1'b1; ps[5] = 1'b1;
        ps[16] = 1'b1; ps[18] = 1'b1; ps[20] = 1'b1; ps[22] = 1'b1;
        ps[26] = 1'b1; ps[30] = 1'b1;
        pcl[24] = 1'b1;
        qa.push_back(mk(3, 1'b0, base + 16));
        qa.push_back(mk(2, 1'b0, base + 41));
        drive(ps, pe, pcl, 42, 1'b0);

        n_vec++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("FAIL missing_valid_a: got %0d outstanding windows, want 0", qa.size());
        end
        n_vec++;
        if (qb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_valid_b: got %0d outstanding windows, want 0", qb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
